// File: rtl/cavlc_block_sequencer.sv
// Per-4x4-block CAVLC controller: runs coeff_token, level and zero-decode stages in
// order, muxes the owner's shift request to the barrel shifter and counts bits consumed.
// Optional per-stage watchdog (TimeoutErr port) is compiled in with CAVLC_SEQ_TIMEOUT_EN.
module cavlc_block_sequencer #(
    parameter int BITCNT_W       = 12,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic                Abort,
    input  logic [4:0]          MaxNumCoeff,
    output logic                CtEnable,
    input  logic                CtShiftEn,
    input  logic [4:0]          CtNumShift,
    input  logic                CtDone,
    input  logic [4:0]          CtTotalCoeff,
    output logic                LvEnable,
    input  logic                LvShiftEn,
    input  logic [4:0]          LvNumShift,
    input  logic                LvDone,
    output logic                ZdEnable,
    input  logic                ZdShiftEn,
    input  logic [4:0]          ZdNumShift,
    input  logic                ZdDone,
    output logic                ShiftEn,
    output logic [4:0]          NumShift,
    output logic [4:0]          TotalCoeff,
    output logic                Busy,
    output logic                BlockDone,
    output logic [BITCNT_W-1:0] BitsConsumed,
`ifdef CAVLC_SEQ_TIMEOUT_EN
    output logic                TimeoutErr,
`endif
    output logic                ProtoErr
);

    typedef enum logic [2:0] {IDLE, CT, LV, ZD, GAP, FIN} state_t;

    state_t     state, state_nx;
    state_t     next_stage, next_stage_nx;
    logic [4:0] max_coeff;
    logic       fwd_en;
    logic [4:0] fwd_num;
    logic       stray;
    logic       stage_done;
    logic       start_acc;
    logic       in_stage;

    assign in_stage  = (state == CT) || (state == LV) || (state == ZD);
    assign start_acc = Start && !Abort && (state == IDLE);

    assign CtEnable  = (state == CT);
    assign LvEnable  = (state == LV);
    assign ZdEnable  = (state == ZD);
    assign Busy      = (state != IDLE);
    assign BlockDone = (state == FIN) && !Abort;

    // Owner mux: only the active stage reaches the shifter; anyone else is a protocol error.
    always_comb begin
        fwd_en     = 1'b0;
        fwd_num    = 5'd0;
        stage_done = 1'b0;
        stray      = CtShiftEn | LvShiftEn | ZdShiftEn;
        case (state)
            CT: begin
                fwd_en = CtShiftEn; fwd_num = CtNumShift; stage_done = CtDone;
                stray  = LvShiftEn | ZdShiftEn;
            end
            LV: begin
                fwd_en = LvShiftEn; fwd_num = LvNumShift; stage_done = LvDone;
                stray  = CtShiftEn | ZdShiftEn;
            end
            ZD: begin
                fwd_en = ZdShiftEn; fwd_num = ZdNumShift; stage_done = ZdDone;
                stray  = CtShiftEn | LvShiftEn;
            end
            default: ;
        endcase
    end

    assign ShiftEn  = fwd_en && !Abort;
    assign NumShift = fwd_num;

`ifdef CAVLC_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] stage_cnt;
    logic          timeout_hit;

    assign timeout_hit = in_stage && !stage_done && (stage_cnt == TW'(TIMEOUT_CYCLES - 1));

    // GAP always separates stages, so leaving a stage state is enough to re-arm the count.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stage_cnt  <= '0;
            TimeoutErr <= 1'b0;
        end else begin
            stage_cnt <= in_stage ? stage_cnt + TW'(1) : '0;
            if (start_acc)
                TimeoutErr <= 1'b0;
            else if (timeout_hit && !Abort)
                TimeoutErr <= 1'b1;
        end
    end
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            next_stage <= IDLE;
        end else begin
            state      <= state_nx;
            next_stage <= next_stage_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        next_stage_nx = next_stage;
        if (Abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE: if (Start) state_nx = CT;
                CT: if (CtDone) begin
                    next_stage_nx = (CtTotalCoeff == 5'd0) ? FIN : LV;
                    state_nx      = GAP;
                end
                LV: if (LvDone) begin
                    // total_zeros is not coded when the block is full
                    next_stage_nx = (TotalCoeff == max_coeff) ? FIN : ZD;
                    state_nx      = GAP;
                end
                ZD: if (ZdDone) begin
                    next_stage_nx = FIN;
                    state_nx      = GAP;
                end
                GAP:     state_nx = next_stage;
                FIN:     state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
`ifdef CAVLC_SEQ_TIMEOUT_EN
            if (timeout_hit) state_nx = IDLE;
`endif
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            max_coeff    <= 5'd0;
            TotalCoeff   <= 5'd0;
            BitsConsumed <= '0;
            ProtoErr     <= 1'b0;
        end else begin
            if (start_acc) begin
                max_coeff    <= MaxNumCoeff;
                TotalCoeff   <= 5'd0;
                BitsConsumed <= '0;
            end else if (ShiftEn) begin
                BitsConsumed <= BitsConsumed + BITCNT_W'(NumShift);
            end
            if (state == CT && CtDone && !Abort)
                TotalCoeff <= CtTotalCoeff;
            if (stray)
                ProtoErr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cavlc_block_sequencer.sv
// Scoreboard bench for cavlc_block_sequencer: a driver plays the three sub-decoders,
// a negedge monitor checks each BlockDone against the expected block summary.
module tb_cavlc_block_sequencer;
    localparam int BW = 12;

    logic          Clk = 0, Reset = 1, Start = 0, Abort = 0;
    logic [4:0]    MaxNumCoeff = 0, CtTotalCoeff = 0;
    logic [2:0]    sh_en = '0, dn = '0;
    logic [4:0]    sh_num [3] = '{5'd0, 5'd0, 5'd0};
    logic          CtEnable, LvEnable, ZdEnable, ShiftEn, Busy, BlockDone, ProtoErr;
    logic [4:0]    NumShift, TotalCoeff;
    logic [BW-1:0] BitsConsumed;
`ifdef CAVLC_SEQ_TIMEOUT_EN
    logic          TimeoutErr;
`endif
    logic [2:0]    en;

    assign en = {ZdEnable, LvEnable, CtEnable};

    always #5 Clk = ~Clk;

    cavlc_block_sequencer #(.BITCNT_W(BW), .TIMEOUT_CYCLES(8)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Abort(Abort), .MaxNumCoeff(MaxNumCoeff),
        .CtEnable(CtEnable), .CtShiftEn(sh_en[0]), .CtNumShift(sh_num[0]), .CtDone(dn[0]),
        .CtTotalCoeff(CtTotalCoeff),
        .LvEnable(LvEnable), .LvShiftEn(sh_en[1]), .LvNumShift(sh_num[1]), .LvDone(dn[1]),
        .ZdEnable(ZdEnable), .ZdShiftEn(sh_en[2]), .ZdNumShift(sh_num[2]), .ZdDone(dn[2]),
        .ShiftEn(ShiftEn), .NumShift(NumShift), .TotalCoeff(TotalCoeff), .Busy(Busy),
        .BlockDone(BlockDone), .BitsConsumed(BitsConsumed),
`ifdef CAVLC_SEQ_TIMEOUT_EN
        .TimeoutErr(TimeoutErr),
`endif
        .ProtoErr(ProtoErr)
    );

    typedef struct {
        int bits; int tc; int busy; int ct_n; int lv_n; int zd_n; bit proto;
    } exp_t;

    exp_t sb[$];
    int   total = 0, bad = 0;
    bit   exp_proto = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: accumulate per-block cycle counts while Busy, compare on BlockDone.
    int busy_n = 0, ct_n = 0, lv_n = 0, zd_n = 0;
    bit overlap = 0;
    always @(negedge Clk) begin
        if (!Reset) begin
            if (!Busy) begin
                busy_n = 0; ct_n = 0; lv_n = 0; zd_n = 0; overlap = 0;
            end else begin
                busy_n++;
                ct_n += int'(CtEnable); lv_n += int'(LvEnable); zd_n += int'(ZdEnable);
                if ($countones(en) > 1) overlap = 1;
            end
            if (BlockDone) begin
                if (sb.size() == 0) begin
                    chk("unexpected_blockdone", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("bits_consumed", 32'(BitsConsumed), e.bits % (1 << BW));
                    chk("total_coeff", 32'(TotalCoeff), e.tc);
                    chk("busy_cycles", busy_n, e.busy);
                    chk("ct_cycles", ct_n, e.ct_n);
                    chk("lv_cycles", lv_n, e.lv_n);
                    chk("zd_cycles", zd_n, e.zd_n);
                    chk("proto_err", 32'(ProtoErr), 32'(e.proto));
                    chk("enable_overlap", 32'(overlap), 0);
                end
            end
        end
    end

    // Play sub-decoder s for d cycles once its enable shows; Done on the last cycle if asked.
    task automatic do_stage(input int s, input int d, input bit with_done, input bit inject,
                            output int bits);
        int w = 0;
        bits = 0;
        while (!en[s] && w < 10) begin @(posedge Clk); #1; w++; end
        chk($sformatf("stage%0d_enable", s), 32'(en[s]), 1);
        for (int k = 0; k < d; k++) begin
            bit         e;
            logic [4:0] n;
            e = 1'($urandom_range(0, 1));
            n = e ? 5'($urandom_range(1, 16)) : 5'd0;
            sh_en = '0; dn = '0;
            sh_num[0] = 0; sh_num[1] = 0; sh_num[2] = 0;
            sh_en[s] = e; sh_num[s] = n; dn[s] = with_done && (k == d - 1);
            if (inject && k == 0) begin
                sh_en[(s + 1) % 3] = 1'b1; sh_num[(s + 1) % 3] = 5'd7; exp_proto = 1;
            end
            #1;
            chk("shift_en_fwd", 32'(ShiftEn), 32'(e));
            chk("num_shift_fwd", 32'(NumShift), 32'(n));
            bits += int'(n);
            @(posedge Clk); #1;
        end
        sh_en = '0; dn = '0;
        sh_num[0] = 0; sh_num[1] = 0; sh_num[2] = 0;
    endtask

    task automatic wait_idle(input string name);
        int w = 0;
        while (Busy && w < 20) begin @(posedge Clk); #1; w++; end
        chk(name, 32'(Busy), 0);
    endtask

    // Expected behaviour from the block rules: CT always; LV iff tc>0; ZD iff 0<tc<max.
    task automatic run_block(input int max, input int tc, input bit inject);
        int   d[3];
        int   b, bits = 0, nst;
        exp_t e;
        d[0] = $urandom_range(1, 4);
        d[1] = (tc > 0) ? $urandom_range(1, 4) : 0;
        d[2] = (tc > 0 && tc != max) ? $urandom_range(1, 4) : 0;
        nst  = 1 + (d[1] > 0) + (d[2] > 0);
        MaxNumCoeff = 5'(max); CtTotalCoeff = 5'(tc);
        Start = 1; @(posedge Clk); #1; Start = 0;
`ifdef CAVLC_SEQ_TIMEOUT_EN
        chk("timeout_cleared", 32'(TimeoutErr), 0);
`endif
        for (int s = 0; s < 3; s++)
            if (d[s] > 0) begin
                do_stage(s, d[s], 1, inject && s == 0, b);
                bits += b;
                if (s == 0) chk("tc_after_ct", 32'(TotalCoeff), tc);
            end
        e = '{bits, tc, d[0] + d[1] + d[2] + nst + 1, d[0], d[1], d[2], exp_proto};
        sb.push_back(e);
        wait_idle("idle_after_block");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int b, bits;
        @(posedge Clk); @(posedge Clk); #1;
        chk("reset_outputs", {CtEnable, LvEnable, ZdEnable, ShiftEn, NumShift, TotalCoeff,
                              Busy, BlockDone, BitsConsumed, ProtoErr}, 0);
        Reset = 0;
        @(posedge Clk); #1;

        run_block(16, 0, 0);
        run_block(16, 5, 0);
        run_block(15, 15, 0);
        run_block(4, 4, 0);
        for (int i = 0; i < 30; i++) begin
            int mx, tc;
            mx = (i % 3 == 0) ? 16 : (i % 3 == 1) ? 15 : 4;
            case ($urandom_range(0, 2))
                0:       tc = 0;
                1:       tc = mx;
                default: tc = $urandom_range(1, mx - 1);
            endcase
            run_block(mx, tc, 0);
        end

        // Abort in LV: back to IDLE, bit count held, no BlockDone.
        MaxNumCoeff = 16; CtTotalCoeff = 5;
        Start = 1; @(posedge Clk); #1; Start = 0;
        do_stage(0, 2, 1, 0, bits);
        @(posedge Clk); #1;
        chk("lv_before_abort", 32'(LvEnable), 1);
        Abort = 1; @(posedge Clk); #1; Abort = 0;
        chk("abort_idle", {Busy, LvEnable}, 0);
        chk("abort_bits_held", 32'(BitsConsumed), bits % (1 << BW));
        @(posedge Clk); #1;
        chk("no_done_after_abort", 32'(BlockDone), 0);
        run_block(16, 7, 0);

        // Asynchronous reset mid-CT drops the enable without waiting for a clock edge.
        Start = 1; @(posedge Clk); #1; Start = 0;
        #2 Reset = 1; #1;
        chk("async_reset_enable", {CtEnable, Busy}, 0);
        @(posedge Clk); #1; Reset = 0;
        @(posedge Clk); #1;

        // Stray LvShiftEn during CT: dropped, ProtoErr sticky, decode unaffected.
        chk("proto_clear_before", 32'(ProtoErr), 0);
        run_block(16, 5, 1);
        run_block(15, 3, 0);

`ifdef CAVLC_SEQ_TIMEOUT_EN
        MaxNumCoeff = 16; CtTotalCoeff = 3;
        Start = 1; @(posedge Clk); #1; Start = 0;
        do_stage(0, 1, 1, 0, b);
        do_stage(1, 1, 1, 0, b);
        do_stage(2, 8, 0, 0, b);
        chk("timeout_idle", 32'(Busy), 0);
        chk("timeout_err", 32'(TimeoutErr), 1);
        @(posedge Clk); #1;
        run_block(16, 2, 0);
`endif

        repeat (3) @(posedge Clk);
        #1;
        chk("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cavlc_block_sequencer.md
Name: cavlc_block_sequencer

Overview:
- Per-4x4-block controller for the CAVLC decoder.
- Sequences three sub-decoders in order: coeff_token, level, then total_zeros/run_before (zero decode).
- Gives exactly one sub-decoder ownership of the shared bitstream barrel shifter at a time, forwards its shift requests, and counts bits consumed.
- Sits between the slice-level parser (Start/BlockDone) and the sub-decoders.

Parameters:
- BITCNT_W, 12, width of BitsConsumed counter (wraps modulo 2^BITCNT_W).
- TIMEOUT_CYCLES, 64, watchdog limit per stage (used only with the optional feature).

Ports:
- Clk  in  1  clock; all logic rising-edge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  one-cycle pulse: begin a block; ignored unless Busy=0.
- Abort  in  1  synchronous: return to IDLE next edge, all enables low.
- MaxNumCoeff  in  5  16, 15 or 4 for the current block type; sampled on accepted Start.
- CtEnable  out  1  coeff_token stage enable.
- CtShiftEn  in  1  coeff_token shift request.
- CtNumShift  in  5  coeff_token shift amount.
- CtDone  in  1  coeff_token done.
- CtTotalCoeff  in  5  TotalCoeff result; valid with CtDone.
- LvEnable  out  1  level stage enable.
- LvShiftEn  in  1  level shift request.
- LvNumShift  in  5  level shift amount.
- LvDone  in  1  level done.
- ZdEnable  out  1  zero-decode stage enable.
- ZdShiftEn  in  1  zero-decode shift request.
- ZdNumShift  in  5  zero-decode shift amount.
- ZdDone  in  1  zero-decode done.
- ShiftEn  out  1  shift request to the barrel shifter.
- NumShift  out  5  shift amount to the barrel shifter.
- TotalCoeff  out  5  registered TotalCoeff of the current block; drives level/zero stages.
- Busy  out  1  high whenever state is not IDLE.
- BlockDone  out  1  one-cycle pulse at block completion.
- BitsConsumed  out  BITCNT_W  running total of bits shifted.
- ProtoErr  out  1  sticky: a non-owner stage asserted ShiftEn.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0.
- States: IDLE, CT, LV, ZD, GAP, FIN.
- Enables are registered and decoded from state: CtEnable=(state==CT), LvEnable=(state==LV), ZdEnable=(state==ZD).
- IDLE:
  - Start accepted -> CT.
  - MaxNumCoeff latched, TotalCoeff cleared.
  - Start at edge N gives CtEnable=1 after edge N.
- CT, LV, ZD:
  - The stage is held enabled until its Done is sampled high.
  - On Done: go to GAP and record the next stage.
  - Enable is low for at least one full cycle after Done, so the sub-decoder returns to its idle state.
- On CtDone:
  - TotalCoeff <= CtTotalCoeff.
  - Next stage is FIN if CtTotalCoeff==0.
  - Next stage is ZD only, skipping LV, is never allowed; LV always follows when TotalCoeff>0.
- On LvDone:
  - Next stage is FIN if TotalCoeff==MaxNumCoeff (total_zeros not coded).
  - Otherwise next stage is ZD.
- On ZdDone: next stage is FIN.
- GAP: exactly one cycle, then the recorded next stage.
- FIN:
  - BlockDone=1 for exactly one cycle, then IDLE.
  - Start in FIN is ignored.
- Shifter ownership (combinational, same cycle):
  - ShiftEn/NumShift = the owner stage's ShiftEn/NumShift.
  - ShiftEn=0 and NumShift=0 in IDLE, GAP and FIN.
  - Requests from non-owner stages are dropped; ProtoErr is set sticky (cleared only by Reset).
- BitsConsumed:
  - Adds NumShift each cycle ShiftEn=1, modulo 2^BITCNT_W.
  - Cleared on accepted Start.
- Simultaneous events:
  - Done and ShiftEn in the same cycle: the shift is forwarded and counted.
  - Abort has priority over everything except Reset.
  - Abort in IDLE: no effect.
  - Abort elsewhere: IDLE next edge, no BlockDone, BitsConsumed held.
- Reset mid-operation: immediate return to IDLE, all enables low asynchronously.

Optional Feature:
- Macro CAVLC_SEQ_TIMEOUT_EN.
- When defined:
  - A per-stage counter clears on entry to CT/LV/ZD and increments each cycle in those states.
  - If it reaches TIMEOUT_CYCLES without Done: go to IDLE and assert output TimeoutErr (1-bit, sticky until next accepted Start or Reset); no BlockDone.
- When undefined: no counter, no TimeoutErr port; stages may take unbounded time.

Test Plan:
- Start, MaxNumCoeff=16, CtTotalCoeff=0, CtDone after 3 cycles with one 1-bit shift -> CtEnable for 3 cycles, GAP, BlockDone; LvEnable/ZdEnable never high; BitsConsumed=1.
- TotalCoeff=5, MaxNumCoeff=16, Ct shifts 6, Lv shifts 4+3, Zd shifts 4+2 -> order CT, GAP, LV, GAP, ZD, GAP, FIN; BitsConsumed=19; TotalCoeff output=5 from CT done onward.
- MaxNumCoeff=15, CtTotalCoeff=15 -> ZD skipped; BlockDone one cycle after the GAP following LvDone.
- LvShiftEn pulsed while state=CT -> ShiftEn stays 0, ProtoErr=1, sequencing unaffected.
- Abort during LV -> IDLE next edge, LvEnable low, no BlockDone; a subsequent Start decodes normally.
- With CAVLC_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=8, ZdDone never asserted -> after 8 ZD cycles TimeoutErr=1 and state IDLE; next Start clears TimeoutErr.
